// File: rtl/frame_pkg.sv
// Shared frame geometry, sync bytes and loader state encoding.
// The CHK state exists only when FRAME_LOADER_CHECKSUM_EN is defined.
package frame_pkg;

    localparam int FRAME_W      = 320;
    localparam int FRAME_H      = 240;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
    localparam int ADDR_W       = 17;

    localparam logic [7:0] SYNC0 = 8'hAA;
    localparam logic [7:0] SYNC1 = 8'h55;

`ifdef FRAME_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        HI   = 3'd2,
        LO   = 3'd3,
        FIN  = 3'd4,
        CHK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        HI   = 3'd2,
        LO   = 3'd3,
        FIN  = 3'd4
    } state_t;
`endif

endpackage

// File: rtl/rx_timeout.sv
// Idle-gap watchdog: counts enabled cycles since the last clear and flags
// expiry once TIMEOUT_CYC-1 is reached; holds there until cleared.
module rx_timeout #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign expired = enable && (cnt_reg == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clear || !enable) begin
            cnt_reg <= '0;
        end else if (cnt_reg != LIMIT) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/frame_loader.sv
// Loads an AA 55-framed RGB565 image from a show-ahead UART RX FIFO into a
// frame buffer. Optional trailing checksum byte: define FRAME_LOADER_CHECKSUM_EN.
module frame_loader #(
    parameter int         FRAME_PIXELS = frame_pkg::FRAME_PIXELS,
    parameter int         TIMEOUT_CYC  = 1_000_000,
    parameter logic [7:0] SYNC0        = frame_pkg::SYNC0,
    parameter logic [7:0] SYNC1        = frame_pkg::SYNC1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx_fifo_empty,
    input  logic [7:0]                  rx_fifo_data,
    output logic                        rx_fifo_pop,
    output logic                        wr_en,
    output logic [frame_pkg::ADDR_W-1:0] wr_addr,
    output logic [15:0]                 wr_data,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    import frame_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   pix_cnt_reg, pix_cnt_next;
    logic [7:0]          hi_reg, hi_next;
    logic                wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
    logic [15:0]         wr_data_reg, wr_data_next;
    logic                err_reg, err_next;
    logic                pop;
    logic                expired;
`ifdef FRAME_LOADER_CHECKSUM_EN
    logic [7:0]          sum_reg, sum_next;
`endif

    rx_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (busy),
        .clear   (pop),
        .expired (expired)
    );

    // Pop is gated by reset so nothing is consumed while the loader is held.
    assign rx_fifo_pop = pop && !reset;
    assign wr_en       = wr_en_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign err         = err_reg;
    assign done        = (state_reg == FIN);
`ifdef FRAME_LOADER_CHECKSUM_EN
    assign busy        = (state_reg == HI) || (state_reg == LO) || (state_reg == CHK);
`else
    assign busy        = (state_reg == HI) || (state_reg == LO);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            pix_cnt_reg <= '0;
            hi_reg      <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            err_reg     <= 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
            sum_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            pix_cnt_reg <= pix_cnt_next;
            hi_reg      <= hi_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
            err_reg     <= err_next;
`ifdef FRAME_LOADER_CHECKSUM_EN
            sum_reg     <= sum_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        pix_cnt_next = pix_cnt_reg;
        hi_next      = hi_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        err_next     = 1'b0;
        pop          = 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
        sum_next     = sum_reg;
`endif

        case (state_reg)
            IDLE: begin
                pop = !rx_fifo_empty;
                if (pop && rx_fifo_data == SYNC0) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                pop = !rx_fifo_empty;
                if (pop) begin
                    if (rx_fifo_data == SYNC1) begin
                        state_next   = HI;
                        pix_cnt_next = '0;
`ifdef FRAME_LOADER_CHECKSUM_EN
                        sum_next     = '0;
`endif
                    end else if (rx_fifo_data != SYNC0) begin
                        state_next = IDLE;
                    end
                end
            end
            HI: begin
                pop = !rx_fifo_empty;
                if (pop) begin
                    hi_next    = rx_fifo_data;
                    state_next = LO;
`ifdef FRAME_LOADER_CHECKSUM_EN
                    sum_next   = sum_reg + rx_fifo_data;
`endif
                end
            end
            LO: begin
                pop = !rx_fifo_empty;
                if (pop) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = pix_cnt_reg;
                    wr_data_next = {hi_reg, rx_fifo_data};
                    pix_cnt_next = pix_cnt_reg + 1'b1;
`ifdef FRAME_LOADER_CHECKSUM_EN
                    sum_next     = sum_reg + rx_fifo_data;
                    state_next   = (pix_cnt_reg == LAST_PIX) ? CHK : HI;
`else
                    state_next   = (pix_cnt_reg == LAST_PIX) ? FIN : HI;
`endif
                end
            end
`ifdef FRAME_LOADER_CHECKSUM_EN
            CHK: begin
                pop = !rx_fifo_empty;
                if (pop) begin
                    if (rx_fifo_data == sum_reg) begin
                        state_next = FIN;
                    end else begin
                        state_next = IDLE;
                        err_next   = 1'b1;
                    end
                end
            end
`endif
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A pop in the expiry cycle keeps the frame alive.
        if (busy && expired && !pop) begin
            state_next = IDLE;
            err_next   = 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader: a queue-backed FIFO model feeds bytes,
// expected writes are queued as stimulus is built and checked as they appear.
module tb_frame_loader;

    localparam int FP = 16;
    localparam int TO = 100;

    typedef struct {
        logic [16:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        rx_fifo_empty;
    logic [7:0]  rx_fifo_data;
    logic        rx_fifo_pop;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    logic [7:0] rxq[$];
    wr_t        expq[$];
    logic [7:0] sum_model;
    bit         gaps_on;
    int         gap_left;
    int         vectors;
    int         miscompares;
    int         wr_cnt;
    int         done_cnt;
    int         err_cnt;

    frame_loader #(
        .FRAME_PIXELS (FP),
        .TIMEOUT_CYC  (TO),
        .SYNC0        (8'hAA),
        .SYNC1        (8'h55)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_fifo_empty (rx_fifo_empty),
        .rx_fifo_data  (rx_fifo_data),
        .rx_fifo_pop   (rx_fifo_pop),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pixel(input int idx, input logic [15:0] px, input bit expect_wr);
        rxq.push_back(px[15:8]);
        rxq.push_back(px[7:0]);
        sum_model = sum_model + px[15:8] + px[7:0];
        if (expect_wr) expq.push_back('{addr: 17'(idx), data: px});
    endtask

    task automatic push_header();
        rxq.push_back(8'hAA);
        rxq.push_back(8'h55);
        sum_model = 8'h00;
    endtask

    task automatic push_sum(input bit good);
`ifdef FRAME_LOADER_CHECKSUM_EN
        rxq.push_back(good ? sum_model : sum_model + 8'd1);
`else
        if (!good) sum_model = 8'h00;
`endif
    endtask

    task automatic send_frame(input logic [15:0] base);
        push_header();
        for (int i = 0; i < FP; i++) push_pixel(i, base + 16'(i), 1'b1);
        push_sum(1'b1);
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        check(tag, 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_err(input int target, input string tag);
        int n = 0;
        while (err_cnt < target && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        check(tag, 32'(err_cnt), 32'(target));
    endtask

    // FIFO model: presents the head at negedge, consumes it just before posedge.
    initial begin
        rx_fifo_empty = 1'b1;
        rx_fifo_data  = 8'h00;
        gap_left      = 0;
        forever begin
            @(negedge clk);
            if (gap_left > 0) begin
                rx_fifo_empty = 1'b1;
                gap_left--;
            end else begin
                rx_fifo_empty = (rxq.size() == 0);
            end
            rx_fifo_data = (rxq.size() != 0) ? rxq[0] : 8'h00;
            #4;
            if (rx_fifo_pop) begin
                check("pop_while_empty", 32'(rx_fifo_empty), 32'd0);
                if (!rx_fifo_empty && rxq.size() != 0) begin
                    void'(rxq.pop_front());
                    if (gaps_on) gap_left = $urandom_range(0, 5);
                end
            end
        end
    end

    // Output monitor, one line per write and per done/err pulse.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk); #1;
            if (wr_en) begin
                wr_cnt++;
                $display("write addr=%0d data=%04h", wr_addr, wr_data);
                check("spurious_write", 32'(expq.size() == 0), 32'd0);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                end
            end
            if (done) begin
                done_cnt++;
                $display("done pulse");
            end
            if (err) begin
                err_cnt++;
                $display("err pulse");
            end
        end
    end

    initial begin
        int base_wr;
        int base_err;
        int base_done;
        int n;
        vectors     = 0;
        miscompares = 0;
        wr_cnt      = 0;
        done_cnt    = 0;
        err_cnt     = 0;
        gaps_on     = 1'b0;
        sum_model   = 8'h00;
        reset       = 1'b1;

        // Reset state, with a byte waiting that must not be popped
        rxq.push_back(8'hAA);
        repeat (3) @(posedge clk);
        #2;
        check("rst_pop",     32'(rx_fifo_pop), 32'd0);
        check("rst_wr_en",   32'(wr_en),       32'd0);
        check("rst_wr_addr", 32'(wr_addr),     32'd0);
        check("rst_wr_data", 32'(wr_data),     32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_done",    32'(done),        32'd0);
        check("rst_err",     32'(err),         32'd0);
        rxq.delete();
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Two back-to-back frames; the second header waits out FIN in the FIFO
        base_wr = wr_cnt;
        send_frame(16'h0000);
        send_frame(16'h0100);
        wait_done(2, "two_frames_done");
        repeat (3) @(posedge clk); #2;
        check("two_frames_writes", 32'(wr_cnt - base_wr), 32'(2 * FP));
        check("two_frames_busy",   32'(busy),             32'd0);
        check("two_frames_err",    32'(err_cnt),          32'd0);

        // Header hunt through junk, plus an AA55 pixel taken as data
        base_wr = wr_cnt;
        rxq.push_back(8'h12); rxq.push_back(8'hAA); rxq.push_back(8'h33);
        rxq.push_back(8'hAA); rxq.push_back(8'hAA); rxq.push_back(8'h55);
        sum_model = 8'h00;
        push_pixel(0, 16'h1234, 1'b1);
        push_pixel(1, 16'hAA55, 1'b1);
        for (int i = 2; i < FP; i++) push_pixel(i, 16'(i * 3 + 7), 1'b1);
        push_sum(1'b1);
        wait_done(3, "resync_done");
        repeat (3) @(posedge clk); #2;
        check("resync_writes", 32'(wr_cnt - base_wr), 32'(FP));

        // Timeout after three pixels
        base_wr   = wr_cnt;
        base_done = done_cnt;
        push_header();
        for (int i = 0; i < 3; i++) push_pixel(i, 16'hBEE0 + 16'(i), 1'b1);
        wait_err(1, "timeout_err");
        #1;
        check("timeout_busy",   32'(busy),               32'd0);
        check("timeout_writes", 32'(wr_cnt - base_wr),   32'd3);
        repeat (3) @(posedge clk); #2;
        check("timeout_err_once", 32'(err_cnt),            32'd1);
        check("timeout_no_done",  32'(done_cnt - base_done), 32'd0);

        // Reset after ten pixels of a frame
        base_wr = wr_cnt;
        push_header();
        for (int i = 0; i < FP; i++) push_pixel(i, 16'h5000 + 16'(i), i < 10);
        push_sum(1'b1);
        n = 0;
        while (wr_cnt - base_wr < 10 && n < 1000) begin
            @(posedge clk); #2;
            n++;
        end
        check("midrst_reach10", 32'(wr_cnt - base_wr), 32'd10);
        reset = 1'b1;
        #1;
        check("midrst_wr_en", 32'(wr_en),   32'd0);
        check("midrst_addr",  32'(wr_addr), 32'd0);
        check("midrst_data",  32'(wr_data), 32'd0);
        check("midrst_busy",  32'(busy),    32'd0);
        check("midrst_done",  32'(done),    32'd0);
        check("midrst_err",   32'(err),     32'd0);
        check("midrst_pop",   32'(rx_fifo_pop), 32'd0);
        rxq.delete();
        repeat (2) @(posedge clk); #2;
        check("midrst_writes", 32'(wr_cnt - base_wr), 32'd10);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        base_wr = wr_cnt;
        send_frame(16'h7700);
        wait_done(4, "after_rst_done");
        repeat (3) @(posedge clk); #2;
        check("after_rst_writes", 32'(wr_cnt - base_wr), 32'(FP));

        // Random FIFO underrun gaps between bytes
        gaps_on = 1'b1;
        base_wr = wr_cnt;
        send_frame(16'hC3A0);
        wait_done(5, "gaps_done");
        repeat (3) @(posedge clk); #2;
        check("gaps_writes", 32'(wr_cnt - base_wr), 32'(FP));
        gaps_on = 1'b0;

`ifdef FRAME_LOADER_CHECKSUM_EN
        // Corrupted checksum: all pixels written, err instead of done
        base_wr   = wr_cnt;
        base_done = done_cnt;
        base_err  = err_cnt;
        push_header();
        for (int i = 0; i < FP; i++) push_pixel(i, 16'h0102 + 16'(i * 257), 1'b1);
        push_sum(1'b0);
        wait_err(base_err + 1, "badsum_err");
        repeat (3) @(posedge clk); #2;
        check("badsum_writes",  32'(wr_cnt - base_wr),     32'(FP));
        check("badsum_no_done", 32'(done_cnt - base_done), 32'd0);
        check("badsum_busy",    32'(busy),                 32'd0);
`else
        base_err = err_cnt;
        check("no_stray_err", 32'(base_err), 32'd1);
`endif

        repeat (5) @(posedge clk); #2;
        check("leftover_expected", 32'(expq.size()), 32'd0);
        check("leftover_rx_bytes", 32'(rxq.size()),  32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
